// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed driver for a DIGITS-digit common-anode hex display
//
// Purpose: shows one hex nibble per digit by scanning the digits one slot at a
// time. New data is captured into a staging register on load and only becomes
// visible at a frame boundary, so a frame never mixes old and new words.
//
// Ports:
//   CLK100MHZ       system clock, all logic on the rising edge
//   RST             synchronous active-high reset
//   data            hex nibble per digit, digit k at [4k+3:4k]
//   blank           1 = digit k dark
//   dp              1 = decimal point of digit k lit
//   load            capture data/blank/dp into staging this cycle
//   pending         staging holds a load not yet displayed
//   frame_done      one-cycle pulse in the cycle after staging is promoted
//   AN              anode enables, active-low, registered
//   CA..CG, DP      segments a..g and decimal point, active-low, registered

module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  CLK100MHZ,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     AN,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;

  logic [4*DIGITS-1:0]   r_stg_data;
  logic [DIGITS-1:0]     r_stg_blank;
  logic [DIGITS-1:0]     r_stg_dp;
  logic [4*DIGITS-1:0]   r_act_data;
  logic [DIGITS-1:0]     r_act_blank;
  logic [DIGITS-1:0]     r_act_dp;

  logic                  r_pending;
  logic                  r_frame_done;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;      // {a,b,c,d,e,f,g}, active-low
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_boundary;
  logic [3:0]            w_nib;
  logic [6:0]            w_lit;      // {a,b,c,d,e,f,g}, 1 = lit
  logic                  w_dark;
  logic [DIGITS-1:0]     w_an_next;
  logic [6:0]            w_seg_next;
  logic                  w_dp_next;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_idx == IDX_LAST);

  // Current digit's fields from the active (displayed) register.
  assign w_nib  = r_act_data[{r_idx, 2'b00} +: 4];
  assign w_dark = r_act_blank[r_idx];

  always_comb begin
    w_lit = 7'b0000000;
    case (w_nib)
      4'h0: w_lit = 7'b1111110;
      4'h1: w_lit = 7'b0110000;
      4'h2: w_lit = 7'b1101101;
      4'h3: w_lit = 7'b1111001;
      4'h4: w_lit = 7'b0110011;
      4'h5: w_lit = 7'b1011011;
      4'h6: w_lit = 7'b1011111;
      4'h7: w_lit = 7'b1110000;
      4'h8: w_lit = 7'b1111111;
      4'h9: w_lit = 7'b1111011;
      4'hA: w_lit = 7'b1110111;
      4'hB: w_lit = 7'b0011111;
      4'hC: w_lit = 7'b1001110;
      4'hD: w_lit = 7'b0111101;
      4'hE: w_lit = 7'b1001111;
      4'hF: w_lit = 7'b1000111;
      default: w_lit = 7'b0000000;
    endcase
  end

  // Next pin values: a blanked digit turns everything off, including its anode.
  always_comb begin
    w_an_next  = {DIGITS{1'b1}};
    w_seg_next = 7'b1111111;
    w_dp_next  = 1'b1;
    if (!w_dark) begin
      w_an_next  = ~({{(DIGITS-1){1'b0}}, 1'b1} << r_idx);
      w_seg_next = ~w_lit;
      w_dp_next  = ~r_act_dp[r_idx];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_stg_data   <= '0;
      r_stg_blank  <= '1;
      r_stg_dp     <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '1;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= '1;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      // Promotion reads staging as it was before this edge, so a load on the
      // boundary cycle lands in staging and waits for the following frame.
      if (w_boundary) begin
        r_act_data  <= r_stg_data;
        r_act_blank <= r_stg_blank;
        r_act_dp    <= r_stg_dp;
      end

      if (load) begin
        r_stg_data  <= data;
        r_stg_blank <= blank;
        r_stg_dp    <= dp;
        r_pending   <= 1'b1;
      end else if (w_boundary) begin
        r_pending   <= 1'b0;
      end

      r_frame_done <= w_boundary;

      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign pending    = r_pending;
  assign frame_done = r_frame_done;
  assign AN         = r_an;
  assign CA         = r_seg[6];
  assign CB         = r_seg[5];
  assign CC         = r_seg[4];
  assign CD         = r_seg[3];
  assign CE         = r_seg[2];
  assign CF         = r_seg[1];
  assign CG         = r_seg[0];
  assign DP         = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int DIGITS = 8;
  localparam int RDIV   = 4;
  localparam int FRAME  = DIGITS * RDIV;

  logic        CLK100MHZ = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  blank = '1;
  logic [7:0]  dp = '0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_done;
  logic [7:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RST       (RST),
    .data      (data),
    .blank     (blank),
    .dp        (dp),
    .load      (load),
    .pending   (pending),
    .frame_done(frame_done),
    .AN        (AN),
    .CA        (CA),
    .CB        (CB),
    .CC        (CC),
    .CD        (CD),
    .CE        (CE),
    .CF        (CF),
    .CG        (CG),
    .DP        (DP)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_tests = 0;
  int n_fail  = 0;

  // Lit segments per hex value, written as the letters of the display.
  string SEGS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] pins_for(input int n);
    string s;
    logic [6:0] lit;
    s   = SEGS[n];
    lit = '0;
    for (int i = 0; i < s.len(); i++) begin
      int c;
      c = int'(s[i]) - 97;
      lit[6-c] = 1'b1;
    end
    return ~lit;
  endfunction

  // ---------------- reference model: cycles counted since reset ----------------
  int         m_cnt;
  logic [3:0] st_d [8];
  logic       st_b [8];
  logic       st_p [8];
  logic [3:0] ac_d [8];
  logic       ac_b [8];
  logic       ac_p [8];
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_pend, e_fd;

  task automatic model_edge(input logic r, input logic ld, input logic [31:0] d,
                            input logic [7:0] b, input logic [7:0] p);
    int slot;
    if (r) begin
      m_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        st_d[k] = 0; st_b[k] = 1; st_p[k] = 0;
        ac_d[k] = 0; ac_b[k] = 1; ac_p[k] = 0;
      end
      e_pend = 0; e_fd = 0; e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1;
    end else begin
      slot = (m_cnt / RDIV) % DIGITS;
      if (ac_b[slot]) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1;
      end else begin
        e_an  = 8'hFF & ~(8'd1 << slot);
        e_seg = pins_for(int'(ac_d[slot]));
        e_dp  = ~ac_p[slot];
      end
      e_fd = ((m_cnt % FRAME) == FRAME - 1);
      if (e_fd) begin
        for (int k = 0; k < 8; k++) begin
          ac_d[k] = st_d[k]; ac_b[k] = st_b[k]; ac_p[k] = st_p[k];
        end
      end
      if (ld) begin
        for (int k = 0; k < 8; k++) begin
          st_d[k] = d[4*k +: 4]; st_b[k] = b[k]; st_p[k] = p[k];
        end
        e_pend = 1;
      end else if (e_fd) begin
        e_pend = 0;
      end
      m_cnt++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_pins();
    return {CA, CB, CC, CD, CE, CF, CG};
  endfunction

  // One clock: drive inputs, advance model, sample #1 after the edge, compare.
  task automatic step(input logic r, input logic ld, input logic [31:0] d,
                      input logic [7:0] b, input logic [7:0] p);
    RST = r; load = ld; data = d; blank = b; dp = p;
    model_edge(r, ld, d, b, p);
    @(posedge CLK100MHZ);
    #1;
    check("model", {14'd0, AN, seg_pins(), DP, pending, frame_done},
                   {14'd0, e_an, e_seg, e_dp, e_pend, e_fd});
    RST = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 8'h00, 8'h00);
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < FRAME + 8 && !seen; i++) begin
      idle(1);
      if (frame_done === 1'b1) seen = 1;
    end
    if (!seen) check({name, "_fd_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- single-digit vector table ----------------
  typedef struct {
    logic [3:0] nib;
    int         pos;
    logic       blk;
    logic       dpb;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;   // {CA..CG}
    logic       exp_dp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cnt;
    logic [7:0] b;
    vecs[0]  = '{4'h0, 0, 1'b0, 1'b1, 8'hFE, 7'b0000001, 1'b0};
    vecs[1]  = '{4'h1, 1, 1'b0, 1'b0, 8'hFD, 7'b1001111, 1'b1};
    vecs[2]  = '{4'h2, 2, 1'b0, 1'b0, 8'hFB, 7'b0010010, 1'b1};
    vecs[3]  = '{4'hA, 3, 1'b0, 1'b0, 8'hF7, 7'b0001000, 1'b1};
    vecs[4]  = '{4'hB, 4, 1'b0, 1'b1, 8'hEF, 7'b1100000, 1'b0};
    vecs[5]  = '{4'hC, 5, 1'b0, 1'b0, 8'hDF, 7'b0110001, 1'b1};
    vecs[6]  = '{4'hD, 6, 1'b0, 1'b1, 8'hBF, 7'b1000010, 1'b0};
    vecs[7]  = '{4'hF, 7, 1'b0, 1'b0, 8'h7F, 7'b0111000, 1'b1};
    vecs[8]  = '{4'h7, 7, 1'b0, 1'b0, 8'h7F, 7'b0001111, 1'b1};
    vecs[9]  = '{4'h8, 0, 1'b0, 1'b0, 8'hFE, 7'b0000000, 1'b1};
    vecs[10] = '{4'h5, 3, 1'b1, 1'b1, 8'hFF, 7'b1111111, 1'b1};
    vecs[11] = '{4'h4, 2, 1'b0, 1'b0, 8'hFB, 7'b1001100, 1'b1};

    // Reset: three cycles, then a full dark frame.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 8'h00, 8'h00);
    check("reset_an", {24'd0, AN}, 32'hFF);
    check("reset_seg", {25'd0, seg_pins()}, 32'h7F);
    check("reset_flags", {29'd0, DP, pending, frame_done}, 32'b100);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      idle(1);
      if (AN !== 8'hFF || seg_pins() !== 7'h7F || DP !== 1'b1) cnt++;
    end
    check("dark_frame", cnt, 0);

    // Full word 76543210 with dp on digit 0.
    step(0, 1, 32'h76543210, 8'h00, 8'h01);
    check("pend_after_load", {31'd0, pending}, 32'd1);
    wait_fd("word1");
    check("pend_at_fd", {31'd0, pending}, 32'd0);
    idle(1);
    check("d0_an", {24'd0, AN}, 32'hFE);
    check("d0_pins", {24'd0, seg_pins(), DP}, {24'd0, 7'b0000001, 1'b0});
    idle(4);
    check("d1_an", {24'd0, AN}, 32'hFD);
    check("d1_pins", {24'd0, seg_pins(), DP}, {24'd0, 7'b1001111, 1'b1});
    idle(24);
    check("d7_pins", {16'd0, AN, seg_pins(), DP}, {16'd0, 8'h7F, 7'b0001111, 1'b1});
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      idle(1);
      if (frame_done === 1'b1) cnt++;
    end
    check("single_fd_pulse", cnt, 0);

    // FEDCBA98 with only digit 0 visible.
    step(0, 1, 32'hFEDCBA98, 8'hFE, 8'h00);
    wait_fd("word2");
    cnt = 0;
    for (int i = 1; i <= FRAME; i++) begin
      idle(1);
      if (i <= RDIV) begin
        if (AN !== 8'hFE || seg_pins() !== 7'b0000000) cnt++;
      end else if (AN !== 8'hFF) cnt++;
    end
    check("only_slot0", cnt, 0);

    // Mid-frame load at slot 3.
    for (int i = 0; i < 2 * FRAME && ((m_cnt / RDIV) % DIGITS) != 3; i++) idle(1);
    step(0, 1, 32'h11111111, 8'h00, 8'h00);
    check("mid_pend", {31'd0, pending}, 32'd1);
    wait_fd("mid");
    check("mid_pend_fall", {31'd0, pending}, 32'd0);
    idle(1);
    check("mid_new_d0", {16'd0, AN, seg_pins(), DP}, {16'd0, 8'hFE, 7'b1001111, 1'b1});

    // Load landing on the boundary cycle.
    step(0, 1, 32'h22222222, 8'h00, 8'h00);
    for (int i = 0; i < 2 * FRAME && (m_cnt % FRAME) != FRAME - 1; i++) idle(1);
    step(0, 1, 32'h33333333, 8'h00, 8'h00);
    check("bnd_fd", {31'd0, frame_done}, 32'd1);
    check("bnd_pend", {31'd0, pending}, 32'd1);
    idle(1);
    check("bnd_old_shown", {25'd0, seg_pins()}, {25'd0, 7'b0010010});
    wait_fd("bnd_second");
    check("bnd_pend_fall", {31'd0, pending}, 32'd0);
    idle(1);
    check("bnd_new_shown", {25'd0, seg_pins()}, {25'd0, 7'b0000110});

    // Reset during slot 5 with a pending load.
    step(0, 1, 32'h44444444, 8'h00, 8'h00);
    for (int i = 0; i < 2 * FRAME && ((m_cnt / RDIV) % DIGITS) != 5; i++) idle(1);
    step(1, 0, 32'h0, 8'h00, 8'h00);
    check("rst5_an", {24'd0, AN}, 32'hFF);
    check("rst5_pend", {31'd0, pending}, 32'd0);
    step(0, 1, 32'h0, 8'h00, 8'h00);
    idle(2 * FRAME);

    // Table-driven single-digit vectors.
    for (int v = 0; v < 12; v++) begin
      b = 8'hFF;
      if (!vecs[v].blk) b[vecs[v].pos] = 1'b0;
      step(0, 1, {28'd0, vecs[v].nib} << (4 * vecs[v].pos), b,
           {7'd0, vecs[v].dpb} << vecs[v].pos);
      wait_fd("vec");
      idle(1 + RDIV * vecs[v].pos);
      check($sformatf("vec%0d", v), {16'd0, AN, seg_pins(), DP},
            {16'd0, vecs[v].exp_an, vecs[v].exp_seg, vecs[v].exp_dp});
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic r, ld;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 9) == 0);
      step(r, ld, $urandom, 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
